irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: synchronised IRQ lines, masked fixed-priority
// pending latch and an ack/done handshake. Define IRQ_CTRL_NESTING_EN to allow nesting.
module irq_ctrl #(
   parameter int unsigned IRQ_CH = 8,
   parameter int unsigned VEC_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IRQ_CH-1:0] irq,
   input  logic              reg_we,
   input  logic [1:0]        reg_addr,
   input  logic [31:0]       reg_wdata,
   output logic [31:0]       reg_rdata,
   output logic              int_req,
   output logic [VEC_W-1:0]  int_vec,
   input  logic              int_ack,
   input  logic              int_done,
   output logic              in_service
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [IRQ_CH-1:0] CH_ONE = {{(IRQ_CH-1){1'b0}}, 1'b1};

   state_t              state;
   state_t              state_next;
   logic [VEC_W-1:0]    vec_next;
   logic [IRQ_CH-1:0]   sync1;
   logic [IRQ_CH-1:0]   sync2;
   logic [IRQ_CH-1:0]   sync_d;
   logic [IRQ_CH-1:0]   mask;
   logic [IRQ_CH-1:0]   edge_cfg;
   logic [IRQ_CH-1:0]   pend;
   logic [IRQ_CH-1:0]   inservice;
   logic [IRQ_CH-1:0]   isr_next;
   logic [IRQ_CH-1:0]   rise;
   logic [IRQ_CH-1:0]   eligible;
   logic [IRQ_CH-1:0]   vec_oh;
   logic [IRQ_CH-1:0]   sw_clr;
   logic [IRQ_CH-1:0]   ack_clr;
   logic [VEC_W-1:0]    low_elig;
   logic                elig_any;
   logic                vec_elig;
   logic                ack_take;
   logic                unused_wdata;
`ifdef IRQ_CTRL_NESTING_EN
   logic [IRQ_CH-1:0]   isr_low;
`endif

   assign unused_wdata = ^reg_wdata;

   assign rise     = sync2 & ~sync_d;
   assign eligible = pend & ~mask;
   assign vec_oh   = CH_ONE << int_vec;
   assign vec_elig = |(eligible & vec_oh);
   assign sw_clr   = (reg_we && reg_addr == 2'd1) ? reg_wdata[IRQ_CH-1:0] : '0;
   assign ack_clr  = ack_take ? vec_oh : '0;
`ifdef IRQ_CTRL_NESTING_EN
   assign isr_low  = inservice & (~inservice + CH_ONE);
`endif

   assign int_req    = (state == REQ);
   assign in_service = |inservice;

   always_comb begin
      low_elig = '0;
      elig_any = 1'b0;
      for (int unsigned i = 0; i < IRQ_CH; i++) begin
         if (eligible[i] && !elig_any) begin
            low_elig = VEC_W'(i);
            elig_any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      vec_next   = int_vec;
      isr_next   = inservice;
      ack_take   = 1'b0;
      case (state)
         IDLE: begin
            if (elig_any) begin
               vec_next   = low_elig;
               state_next = REQ;
            end
         end
         REQ: begin
            if (int_ack) begin
               ack_take   = 1'b1;
               isr_next   = inservice | vec_oh;
               state_next = SERVICE;
            end else if (!vec_elig) begin
               state_next = (inservice != '0) ? SERVICE : IDLE;
            end
         end
         SERVICE: begin
            // done retires the lowest set in-service bit (highest priority level)
            if (int_done) begin
               isr_next = inservice & (inservice - CH_ONE);
               if (isr_next == '0) state_next = IDLE;
            end
`ifdef IRQ_CTRL_NESTING_EN
            else if ((eligible & (isr_low - CH_ONE)) != '0) begin
               vec_next   = low_elig;
               state_next = REQ;
            end
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1     <= '0;
         sync2     <= '0;
         sync_d    <= '0;
         mask      <= '1;
         edge_cfg  <= '0;
         pend      <= '0;
         inservice <= '0;
         int_vec   <= '0;
      end else begin
         sync1     <= irq;
         sync2     <= sync1;
         sync_d    <= sync2;
         inservice <= isr_next;
         int_vec   <= vec_next;
         // edge channels: clears first, then a same-cycle rising edge re-sets
         pend      <= (edge_cfg & ((pend & ~(sw_clr | ack_clr)) | rise))
                    | (~edge_cfg & sync2);
         if (reg_we && reg_addr == 2'd0) mask     <= reg_wdata[IRQ_CH-1:0];
         if (reg_we && reg_addr == 2'd2) edge_cfg <= reg_wdata[IRQ_CH-1:0];
      end
   end

   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         2'd0: reg_rdata = 32'(mask);
         2'd1: reg_rdata = 32'(pend);
         2'd2: reg_rdata = 32'(edge_cfg);
         default: begin
            reg_rdata[VEC_W-1:0] = int_vec;
            reg_rdata[8]         = int_req;
            reg_rdata[9]         = in_service;
            reg_rdata[17:16]     = state;
         end
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with a per-cycle reference model and literal spot checks.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  irq = '0;
   logic        reg_we = 1'b0;
   logic [1:0]  reg_addr = '0;
   logic [31:0] reg_wdata = '0;
   logic [31:0] reg_rdata;
   logic        int_req;
   logic [2:0]  int_vec;
   logic        int_ack = 1'b0;
   logic        int_done = 1'b0;
   logic        in_service;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   irq_ctrl #(.IRQ_CH(8), .VEC_W(3)) dut (
      .clk(clk), .reset(reset), .irq(irq), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .int_req(int_req), .int_vec(int_vec),
      .int_ack(int_ack), .int_done(int_done), .in_service(in_service)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: state 0=idle, 1=request, 2=service; syncs modelled as irq history.
   bit [7:0] m_h1, m_h2, m_h3, m_mask, m_edge, m_pend, m_isr;
   int m_state, m_vec;

   function automatic int lowest(input bit [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 8;
   endfunction

   always @(posedge clk) begin
      bit [7:0] elig, np, nisr;
      int le, li, ns, nv;
      if (!reset) begin
         m_h1 <= '0; m_h2 <= '0; m_h3 <= '0;
         m_mask <= 8'hFF; m_edge <= '0; m_pend <= '0; m_isr <= '0;
         m_state <= 0; m_vec <= 0;
      end else begin
         elig = m_pend & ~m_mask;
         le = lowest(elig);
         li = lowest(m_isr);
         ns = m_state; nv = m_vec; nisr = m_isr;
         for (int i = 0; i < 8; i++) begin
            if (m_edge[i]) begin
               np[i] = m_pend[i];
               if (reg_we && reg_addr == 2'd1 && reg_wdata[i]) np[i] = 1'b0;
               if (m_state == 1 && int_ack && m_vec == i) np[i] = 1'b0;
               if (m_h2[i] && !m_h3[i]) np[i] = 1'b1;
            end else begin
               np[i] = m_h2[i];
            end
         end
         if (m_state == 0) begin
            if (elig != 0) begin nv = le; ns = 1; end
         end else if (m_state == 1) begin
            if (int_ack) begin nisr[m_vec] = 1'b1; ns = 2; end
            else if (!elig[m_vec]) ns = (m_isr != 0) ? 2 : 0;
         end else begin
            if (int_done) begin
               nisr[li] = 1'b0;
               if (nisr == 0) ns = 0;
            end
`ifdef IRQ_CTRL_NESTING_EN
            else if (le < li) begin nv = le; ns = 1; end
`endif
         end
         m_state <= ns; m_vec <= nv; m_isr <= nisr; m_pend <= np;
         m_h1 <= irq; m_h2 <= m_h1; m_h3 <= m_h2;
         if (reg_we && reg_addr == 2'd0) m_mask <= reg_wdata[7:0];
         if (reg_we && reg_addr == 2'd2) m_edge <= reg_wdata[7:0];
      end
   end

   always @(negedge clk) begin
      logic [31:0] exp_rd;
      if (cmp_en) begin
         case (reg_addr)
            2'd0: exp_rd = {24'd0, m_mask};
            2'd1: exp_rd = {24'd0, m_pend};
            2'd2: exp_rd = {24'd0, m_edge};
            default: exp_rd = (m_state << 16) | ((m_isr != 0) << 9)
                             | ((m_state == 1) << 8) | m_vec;
         endcase
         check("model int_req", {31'd0, int_req}, (m_state == 1) ? 1 : 0);
         check("model int_vec", {29'd0, int_vec}, m_vec);
         check("model in_service", {31'd0, in_service}, (m_isr != 0) ? 1 : 0);
         check("model reg_rdata", reg_rdata, exp_rd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      tick();
      reg_we = 1'b0; reg_wdata = '0; reg_addr = 2'd3;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      reg_addr = a;
      #1;
      d = reg_rdata;
   endtask

   task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(name, d, exp);
   endtask

   task automatic wait_req(input int budget);
      int n = 0;
      while (!int_req && n < budget) begin tick(); n++; end
      check("wait int_req timeout", {31'd0, int_req}, 1);
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1; tick(); int_ack = 1'b0;
   endtask

   task automatic pulse_done();
      int_done = 1'b1; tick(); int_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reg_addr = 2'd3;
      ticks(3);
      cmp_en = 1'b1;
      reset = 1'b1;
      check("reset int_req", {31'd0, int_req}, 0);
      check("reset in_service", {31'd0, in_service}, 0);
      rd_check("reset MASK", 2'd0, 32'h0000_00FF);
      rd_check("reset PEND", 2'd1, 32'h0);
      rd_check("reset EDGE", 2'd2, 32'h0);
      rd_check("reset STATUS", 2'd3, 32'h0);

      // single edge pulse on channel 0
      wr(2'd0, 32'h00);
      wr(2'd2, 32'h01);
      irq = 8'h01; tick();
      irq = 8'h00; tick();
      tick();
      rd_check("t1 PEND after k+2", 2'd1, 32'h01);
      check("t1 no req at k+2", {31'd0, int_req}, 0);
      tick();
      check("t1 req at k+3", {31'd0, int_req}, 1);
      rd_check("t1 STATUS REQ", 2'd3, 32'h0001_0100);
      pulse_ack();
      rd_check("t1 PEND cleared by ack", 2'd1, 32'h00);
      rd_check("t1 STATUS SERVICE", 2'd3, 32'h0002_0200);
      pulse_done();
      rd_check("t1 STATUS IDLE", 2'd3, 32'h0);

      // level channels, priority and re-request
      wr(2'd2, 32'h00);
      irq = 8'h0C; ticks(3);
      rd_check("t2 PEND level", 2'd1, 32'h0C);
      tick();
      check("t2 vec 2", {29'd0, int_vec}, 2);
      pulse_ack();
      rd_check("t2 level PEND kept", 2'd1, 32'h0C);
      pulse_done();
      check("t2 idle after done", {31'd0, int_req}, 0);
      tick();
      check("t2 re-request", {31'd0, int_req}, 1);
      check("t2 re-request vec", {29'd0, int_vec}, 2);
      pulse_ack();
      irq = 8'h08; ticks(3);
      rd_check("t2 PEND after drop", 2'd1, 32'h08);
      check("t2 no req in service", {31'd0, int_req}, 0);
      pulse_done();
      tick();
      check("t2 next vec 3", {29'd0, int_vec}, 3);
      pulse_ack();
      irq = 8'h00; ticks(3);
      pulse_done();
      rd_check("t2 STATUS idle vec3", 2'd3, 32'h03);

      // withdraw by masking
      irq = 8'h20;
      wait_req(8);
      check("t3 vec 5", {29'd0, int_vec}, 5);
      wr(2'd0, 32'h20);
      check("t3 req held on write edge", {31'd0, int_req}, 1);
      tick();
      check("t3 withdrawn", {31'd0, int_req}, 0);
      rd_check("t3 STATUS idle", 2'd3, 32'h05);
      rd_check("t3 PEND kept", 2'd1, 32'h20);
      irq = 8'h00; ticks(3);
      wr(2'd0, 32'h00);

      // set beats clear, ack+done together
      wr(2'd0, 32'h02);
      wr(2'd2, 32'h02);
      irq = 8'h02; ticks(2);
      wr(2'd1, 32'h02);
      rd_check("t4 set wins", 2'd1, 32'h02);
      wr(2'd1, 32'h02);
      rd_check("t4 sw clear", 2'd1, 32'h00);
      irq = 8'h00; ticks(2);
      irq = 8'h02; ticks(3);
      rd_check("t4 PEND again", 2'd1, 32'h02);
      wr(2'd0, 32'h00);
      tick();
      check("t4 req", {31'd0, int_req}, 1);
      check("t4 vec 1", {29'd0, int_vec}, 1);
      int_ack = 1'b1; int_done = 1'b1; tick(); int_ack = 1'b0; int_done = 1'b0;
      rd_check("t4 STATUS service", 2'd3, 32'h0002_0201);
      rd_check("t4 PEND ack clear", 2'd1, 32'h00);
      pulse_done();
      check("t4 in_service clear", {31'd0, in_service}, 0);
      irq = 8'h00; ticks(3);

      // nesting
      wr(2'd2, 32'h12);
      irq = 8'h10; tick(); irq = 8'h00;
      wait_req(8);
      check("t5 vec 4", {29'd0, int_vec}, 4);
      pulse_ack();
      irq = 8'h02; tick(); irq = 8'h00; ticks(2);
      tick();
`ifdef IRQ_CTRL_NESTING_EN
      check("t5 nested req", {31'd0, int_req}, 1);
      check("t5 nested vec", {29'd0, int_vec}, 1);
      pulse_ack();
      rd_check("t5 nested service", 2'd3, 32'h0002_0201);
      pulse_done();
      rd_check("t5 outer still served", 2'd3, 32'h0002_0201);
      pulse_done();
      rd_check("t5 idle", 2'd3, 32'h0000_0001);
`else
      check("t5 no nested req", {31'd0, int_req}, 0);
      rd_check("t5 still vec 4", 2'd3, 32'h0002_0204);
      pulse_done();
      tick();
      check("t5 deferred vec", {29'd0, int_vec}, 1);
      pulse_ack();
      pulse_done();
      rd_check("t5 idle", 2'd3, 32'h0000_0001);
`endif

      // reset in SERVICE
      wr(2'd2, 32'h00);
      irq = 8'hFF;
      wait_req(8);
      check("t6 vec 0", {29'd0, int_vec}, 0);
      pulse_ack();
      ticks(2);
      rd_check("t6 PEND full", 2'd1, 32'hFF);
      reset = 1'b0; tick();
      check("t6 int_req", {31'd0, int_req}, 0);
      check("t6 int_vec", {29'd0, int_vec}, 0);
      check("t6 in_service", {31'd0, in_service}, 0);
      rd_check("t6 MASK", 2'd0, 32'hFF);
      rd_check("t6 PEND", 2'd1, 32'h00);
      rd_check("t6 STATUS", 2'd3, 32'h0);
      reset = 1'b1;
      irq = 8'h00; ticks(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
